bram_arbiter: RTL and testbench



---
 rtl/bram_arbiter.sv | 158 +++++++++++++++
 tb/tb_bram_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// Two-requester arbiter/sequencer in front of the single-port BRAM/accumulate datapath.
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module bram_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int RD_LAT     = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic                  req1,
   input  logic [1:0]            op0,
   input  logic [1:0]            op1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rcarry,
   output logic                  busy,
   output logic [2:0]            select,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [DATA_WIDTH-1:0] bram_data,
   input  logic [DATA_WIDTH-1:0] dout,
   input  logic                  cout
);

   localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [1:0] OP_ILLEGAL = 2'b00;
   localparam logic [1:0] OP_WRITE   = 2'b10;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [CW-1:0]         wait_cnt;
   logic [1:0]            cmd_op;
   logic                  cmd_owner;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  grant_any;
   logic                  winner;
   logic [1:0]            win_op;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [DATA_WIDTH-1:0] win_data;

`ifdef ARB_FIXED_PRIO_EN
   always_comb begin
      winner = ~req0;
   end
`else
   logic rr_ptr;

   // rr_ptr names the requester that wins the next simultaneous contest
   always_comb begin
      winner = (req0 && req1) ? rr_ptr : ~req0;
   end

   always_ff @(posedge clk) begin
      if (rst)
         rr_ptr <= 1'b0;
      else if (grant_any)
         rr_ptr <= ~winner;
   end
`endif

   // Grants only in IDLE and never while reset is held, so a pending request is not lost
   always_comb begin
      grant_any = (state == IDLE) && (req0 || req1) && !rst;
      win_op    = winner ? op1    : op0;
      win_addr  = winner ? addr1  : addr0;
      win_data  = winner ? wdata1 : wdata0;
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_any) state_nxt = ISSUE;
         ISSUE: begin
            if (cmd_op == OP_WRITE || cmd_op == OP_ILLEGAL)
               state_nxt = IDLE;
            else if (RD_LAT == 1)
               state_nxt = CAPTURE;
            else
               state_nxt = WAIT;
         end
         WAIT:    if (wait_cnt == CW'(1)) state_nxt = CAPTURE;
         CAPTURE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Illegal ops skip the BRAM entirely and answer with a zero result so the owner is released
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_op    <= OP_ILLEGAL;
         cmd_owner <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         wait_cnt  <= '0;
         rdata     <= '0;
         rcarry    <= 1'b0;
         rvalid0   <= 1'b0;
         rvalid1   <= 1'b0;
      end else begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         if (grant_any) begin
            cmd_op    <= win_op;
            cmd_owner <= winner;
            if (win_op != OP_ILLEGAL) begin
               addr_q <= win_addr;
               data_q <= win_data;
            end
         end
         case (state)
            ISSUE: begin
               wait_cnt <= CW'(RD_LAT - 1);
               if (cmd_op == OP_ILLEGAL) begin
                  rdata   <= '0;
                  rcarry  <= 1'b0;
                  rvalid0 <= ~cmd_owner;
                  rvalid1 <= cmd_owner;
               end
            end
            WAIT: wait_cnt <= wait_cnt - CW'(1);
            CAPTURE: begin
               rdata   <= dout;
               rcarry  <= cout;
               rvalid0 <= ~cmd_owner;
               rvalid1 <= cmd_owner;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy      = (state != IDLE);
      select    = (state != IDLE) ? {1'b0, cmd_op} : 3'b000;
      gnt0      = grant_any && !winner;
      gnt1      = grant_any && winner;
      bram_addr = addr_q;
      bram_data = data_q;
   end

endmodule

// File: tb/tb_bram_arbiter.sv
// Randomized self-checking bench for bram_arbiter with a behavioural BRAM stub and a
// cycle-schedule reference model; build with ARB_FIXED_PRIO_EN to check fixed priority.
module tb_bram_arbiter;

   localparam int DW     = 8;
   localparam int AW     = 4;
   localparam int RD_LAT = 6;

   logic          clk;
   logic          rst;
   logic          req0, req1;
   logic [1:0]    op0, op1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, rvalid0, rvalid1, rcarry, busy, cout;
   logic [DW-1:0] rdata, dout, bram_data;
   logic [2:0]    select;
   logic [AW-1:0] bram_addr;

   bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .op0(op0), .op1(op1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .rcarry(rcarry), .busy(busy), .select(select),
      .bram_addr(bram_addr), .bram_data(bram_data), .dout(dout), .cout(cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural stand-in for the BRAM/accumulate datapath, one cycle of read latency
   logic [DW-1:0] bram_mem [1<<AW];
   always @(posedge clk) begin
      if (select == 3'b010) bram_mem[bram_addr] <= bram_data;
      if (select == 3'b001)
         {cout, dout} <= {1'b0, bram_mem[bram_addr]};
      else if (select == 3'b011)
         {cout, dout} <= {1'b0, bram_mem[bram_addr]} + {1'b0, bram_data};
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Reference model: every grant schedules its select window, free cycle and result
   logic [DW-1:0] ref_mem [1<<AW];
   int            next_free = 0, last_g = -1, sel_lo = -1, sel_hi = -2, rv_cyc = -1;
   int            rv_who = 0, ptr = 0, win = 0;
   logic [2:0]    sel_val = 3'b000;
   logic [DW:0]   rv_sum = '0;
   logic [DW-1:0] exp_rdata = '0, last_data = '0;
   logic          exp_rcarry = 1'b0;
   logic [AW-1:0] last_addr = '0;
   bit            armed = 1'b0;

   // Observations used by the directed checks
   int            gcount [2] = '{0, 0};
   int            rvcount [2] = '{0, 0};
   int            gnt_at [2] = '{0, 0};
   int            rv_lat [2] = '{0, 0};
   logic [DW-1:0] rv_data [2];
   logic          rv_carry [2];
   int            sel_run = 0, last_run = 0;
   int            grant_log [$];

   task automatic resetModel();
      next_free  = cyc + 1;
      last_g     = cyc;
      sel_lo     = -1;
      sel_hi     = -2;
      rv_cyc     = -1;
      ptr        = 0;
      exp_rdata  = '0;
      exp_rcarry = 1'b0;
      last_addr  = '0;
      last_data  = '0;
   endtask

   initial begin
      logic [1:0]    exp_g, exp_rv, m_op;
      logic [AW-1:0] m_a;
      logic [DW-1:0] m_d;
      forever begin
         @(negedge clk);
         if (armed) begin
            exp_g = 2'b00;
            if (!rst && cyc >= next_free && (req0 || req1)) begin
`ifdef ARB_FIXED_PRIO_EN
               win = req0 ? 0 : 1;
`else
               win = (req0 && req1) ? ptr : (req0 ? 0 : 1);
`endif
               exp_g = (win == 1) ? 2'b10 : 2'b01;
            end
            checkOutput("gnt", {gnt1, gnt0}, exp_g);
            checkOutput("busy", busy, (cyc > last_g && cyc < next_free));
            checkOutput("select", select, (cyc >= sel_lo && cyc <= sel_hi) ? sel_val : 3'b000);
            checkOutput("bram_addr", bram_addr, last_addr);
            checkOutput("bram_data", bram_data, last_data);
            exp_rv = (cyc == rv_cyc) ? ((rv_who == 1) ? 2'b10 : 2'b01) : 2'b00;
            checkOutput("rvalid", {rvalid1, rvalid0}, exp_rv);
            if (cyc == rv_cyc) begin
               exp_rdata  = rv_sum[DW-1:0];
               exp_rcarry = rv_sum[DW];
            end
            checkOutput("rdata", rdata, exp_rdata);
            checkOutput("rcarry", rcarry, exp_rcarry);
            if (exp_g != 2'b00) begin
               m_op      = win ? op1 : op0;
               m_a       = win ? addr1 : addr0;
               m_d       = win ? wdata1 : wdata0;
               last_g    = cyc;
               ptr       = (win == 0) ? 1 : 0;
               rv_cyc    = -1;
               sel_lo    = -1;
               sel_hi    = -2;
               next_free = cyc + 2;
               if (m_op != 2'b00) begin
                  last_addr = m_a;
                  last_data = m_d;
                  sel_lo    = cyc + 1;
                  sel_hi    = cyc + 1;
                  sel_val   = {1'b0, m_op};
               end
               case (m_op)
                  2'b01:   rv_sum = {1'b0, ref_mem[m_a]};
                  2'b11:   rv_sum = {1'b0, ref_mem[m_a]} + {1'b0, m_d};
                  2'b10:   ref_mem[m_a] = m_d;
                  default: rv_sum = '0;
               endcase
               if (m_op == 2'b01 || m_op == 2'b11) begin
                  sel_hi    = cyc + 1 + RD_LAT;
                  next_free = cyc + 2 + RD_LAT;
                  rv_cyc    = cyc + 2 + RD_LAT;
               end else if (m_op == 2'b00) begin
                  rv_cyc = cyc + 2;
               end
               rv_who = win;
            end
         end
         if (gnt0 || gnt1) begin
            gcount[gnt1 ? 1 : 0]++;
            gnt_at[gnt1 ? 1 : 0] = cyc;
            grant_log.push_back(gnt1 ? 1 : 0);
         end
         for (int w = 0; w < 2; w++) begin
            if ((w == 0 && rvalid0) || (w == 1 && rvalid1)) begin
               rvcount[w]++;
               rv_lat[w]   = cyc - gnt_at[w];
               rv_data[w]  = rdata;
               rv_carry[w] = rcarry;
            end
         end
         if (select != 3'b000) sel_run++;
         else if (sel_run > 0) begin
            last_run = sel_run;
            sel_run  = 0;
         end
         if (rst) begin
            resetModel();
            armed = 1'b1;
         end
      end
   end

   // Raise a request and hold it until the grant is seen, then drop it
   task automatic applyStimulus(input int who, input logic [1:0] op, input logic [AW-1:0] a,
                                input logic [DW-1:0] d);
      int start, n;
      if (who == 0) begin op0 = op; addr0 = a; wdata0 = d; req0 = 1'b1; end
      else          begin op1 = op; addr1 = a; wdata1 = d; req1 = 1'b1; end
      start = gcount[who];
      n     = 0;
      while (gcount[who] == start && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("grant_wait", gcount[who] != start, 1);
      if (who == 0) req0 = 1'b0;
      else          req1 = 1'b0;
   endtask

   task automatic waitIdle();
      int n = 0;
      while ((cyc < next_free || cyc <= rv_cyc) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("idle_wait", n < 300, 1);
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic randBurst(input int who, input int count);
      for (int k = 0; k < count; k++) begin
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         applyStimulus(who, 2'($urandom_range(0, 3)), AW'($urandom), DW'($urandom));
      end
   endtask

   task automatic readBurst(input int who, input int count);
      for (int k = 0; k < count; k++)
         applyStimulus(who, 2'b01, AW'($urandom), 8'h00);
   endtask

   initial begin
      int gl_start, rv_before;
      int exp_order [8];
      logic [DW-1:0] v;
`ifdef ARB_FIXED_PRIO_EN
      exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
      exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
      for (int i = 0; i < (1 << AW); i++) begin
         v           = DW'($urandom);
         bram_mem[i] = v;
         ref_mem[i]  = v;
      end
      bram_mem[4] = 8'hF0;
      ref_mem[4]  = 8'hF0;
      rst = 1'b1;
      req0 = 1'b0; req1 = 1'b0; op0 = '0; op1 = '0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checkOutput("rst_select", select, 3'b000);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_rvalid", {rvalid1, rvalid0}, 2'b00);
      checkOutput("rst_rdata", rdata, 8'h00);

      $display("[TB] directed write / read / read-add / illegal");
      applyStimulus(0, 2'b10, 4'd3, 8'hA5);
      waitIdle();
      checkOutput("write_sel_len", last_run, 1);
      applyStimulus(1, 2'b01, 4'd3, 8'h00);
      waitIdle();
      checkOutput("read_sel_len", last_run, RD_LAT + 1);
      checkOutput("read_lat", rv_lat[1], RD_LAT + 2);
      checkOutput("read_data", rv_data[1], 8'hA5);
      checkOutput("read_carry", rv_carry[1], 1'b0);
      applyStimulus(0, 2'b11, 4'd4, 8'h20);
      waitIdle();
      checkOutput("radd_data", rv_data[0], 8'h10);
      checkOutput("radd_carry", rv_carry[0], 1'b1);
      applyStimulus(1, 2'b00, 4'd7, 8'h55);
      waitIdle();
      checkOutput("illegal_lat", rv_lat[1], 2);
      checkOutput("illegal_data", rv_data[1], 8'h00);

      $display("[TB] reset during WAIT");
      applyStimulus(0, 2'b01, 4'd5, 8'h00);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      rv_before = rvcount[0];
      @(posedge clk);
      #1 rst = 1'b0;
      checkOutput("abort_select", select, 3'b000);
      checkOutput("abort_busy", busy, 1'b0);
      repeat (RD_LAT + 4) @(posedge clk);
      #1;
      checkOutput("abort_no_rvalid", rvcount[0], rv_before);

      $display("[TB] contested back-to-back reads");
      gl_start = grant_log.size();
      fork
         readBurst(0, 4);
         readBurst(1, 4);
      join
      waitIdle();
      checkOutput("order_count", grant_log.size() - gl_start, 8);
      for (int i = 0; i < 8; i++)
         checkOutput("order", (gl_start + i < grant_log.size()) ? grant_log[gl_start + i] : 32'hFF,
                     exp_order[i]);

      $display("[TB] random traffic");
      fork
         randBurst(0, 40);
         randBurst(1, 40);
      join
      waitIdle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
